// File: rtl/bcd_hex_cascade_counter.sv
// bcd_hex_cascade_counter
//   Multi-digit up/down counter built from DIGITS cascaded 4-bit stages.
//   Each stage counts decimal (0-9) or hexadecimal (0-F). Carry and borrow
//   ripple between stages within one clock cycle.
//
// Ports
//   clk       counter clock, rising edge
//   rst_n     asynchronous active-low reset (count=0, wrap=0)
//   clear     synchronous clear to 0 (highest priority)
//   load      synchronous raw parallel load of load_val
//   load_val  load value, digit i = load_val[4i+3:4i]
//   mode      1 = hex digits, 0 = decimal digits
//   incr      1 = count up, 0 = count down
//   pause     1 = hold count
//   wrap_en   1 = wrap at the terminal value, 0 = saturate
//   count     registered count, digit 0 least significant
//   at_limit  combinational, count equals the terminal value for mode/incr
//   wrap      registered one-cycle pulse after a wrap step
module bcd_hex_cascade_counter #(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mode,
  input  logic         incr,
  input  logic         pause,
  input  logic         wrap_en,
  output logic [W-1:0] count,
  output logic         at_limit,
  output logic         wrap
);

  logic [W-1:0] step_val;
  logic [W-1:0] maxv;
  logic         carry_out;

  // Returns {carry_or_borrow, next_digit} for one digit stage.
  // Decimal digits A..F recover to 0 with carry going up, and to 9 without
  // borrow going down.
  function automatic logic [4:0] digit_step(input logic [3:0] d,
                                            input logic       hex,
                                            input logic       up);
    logic [4:0] r;
    r = '0;
    if (up) begin
      if (hex)              r = {(d == 4'hF), d + 4'd1};
      else if (d >= 4'd9)   r = {1'b1, 4'd0};
      else                  r = {1'b0, d + 4'd1};
    end else begin
      if (hex)              r = {(d == 4'h0), d - 4'd1};
      else if (d == 4'd0)   r = {1'b1, 4'd9};
      else if (d > 4'd9)    r = {1'b0, 4'd9};
      else                  r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  // Ripple chain: en is the enable into the current digit; after the last
  // digit it is the carry/borrow out of the whole counter.
  always_comb begin : ripple
    logic       en;
    logic [4:0] r;
    step_val = count;
    en       = 1'b1;
    r        = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r = digit_step(count[4*i +: 4], mode, incr);
      if (en) step_val[4*i +: 4] = r[3:0];
      en = en & r[4];
    end
    carry_out = en;
  end

  always_comb begin
    maxv = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      maxv[4*i +: 4] = mode ? 4'hF : 4'h9;
    end
  end

  assign at_limit = incr ? (count == maxv) : (count == '0);

  // A carry out of the top digit with wrap disabled covers both saturation
  // at the terminal value and illegal-digit recovery overflow: hold in both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (pause) begin
      wrap  <= 1'b0;
    end else if (carry_out && !wrap_en) begin
      wrap  <= 1'b0;
    end else begin
      count <= step_val;
      wrap  <= carry_out;
    end
  end

endmodule

// File: tb/tb_bcd_hex_cascade_counter.sv
module tb_bcd_hex_cascade_counter;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic         incr;
  logic         pause;
  logic         wrap_en;
  logic [W-1:0] count;
  logic         at_limit;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  bcd_hex_cascade_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .incr     (incr),
    .pause    (pause),
    .wrap_en  (wrap_en),
    .count    (count),
    .at_limit (at_limit),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         clr;
    logic         ld;
    logic [W-1:0] lv;
    logic         md;
    logic         inc;
    logic         ps;
    logic         wen;
    logic [W-1:0] ec;
    logic         el;
    logic         ew;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] ec;
    logic         el;
    logic         ew;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t v(string n, logic c, logic ld, logic [W-1:0] lv,
                             logic md, logic inc, logic ps, logic wen,
                             logic [W-1:0] ec, logic el, logic ew);
    vec_t r;
    r.name = n; r.clr = c; r.ld = ld; r.lv = lv; r.md = md; r.inc = inc;
    r.ps = ps; r.wen = wen; r.ec = ec; r.el = el; r.ew = ew;
    return r;
  endfunction

  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue got 1 expected 0");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".count"}, count, e.ec);
    chk({e.name, ".at_limit"}, W'(at_limit), W'(e.el));
    chk({e.name, ".wrap"}, W'(wrap), W'(e.ew));
  endtask

  // Drive one vector (1ns after an edge), push its expectation, and compare
  // 1ns after the next rising edge.
  task automatic apply(vec_t x);
    exp_t e;
    clear = x.clr; load = x.ld; load_val = x.lv; mode = x.md;
    incr = x.inc; pause = x.ps; wrap_en = x.wen;
    e.name = x.name; e.ec = x.ec; e.el = x.el; e.ew = x.ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic run_table();
    while (vecs.size() > 0) apply(vecs.pop_front());
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic mid_reset(string n);
    rst_n = 1'b0;
    #2;
    chk({n, ".count"}, count, '0);
    chk({n, ".wrap"}, W'(wrap), '0);
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    mode = 1'b0; incr = 1'b1; pause = 1'b0; wrap_en = 1'b1;
    #12;
    chk("reset.count", count, '0);
    chk("reset.wrap", W'(wrap), '0);
    chk("reset.at_limit", W'(at_limit), '0);
    rst_n = 1'b1;

    // Decimal up count from 0: twelve edges.
    vecs.push_back(v("up01", 0,0,8'h00, 0,1,0,1, 8'h01, 0,0));
    vecs.push_back(v("up02", 0,0,8'h00, 0,1,0,1, 8'h02, 0,0));
    vecs.push_back(v("up03", 0,0,8'h00, 0,1,0,1, 8'h03, 0,0));
    vecs.push_back(v("up04", 0,0,8'h00, 0,1,0,1, 8'h04, 0,0));
    vecs.push_back(v("up05", 0,0,8'h00, 0,1,0,1, 8'h05, 0,0));
    vecs.push_back(v("up06", 0,0,8'h00, 0,1,0,1, 8'h06, 0,0));
    vecs.push_back(v("up07", 0,0,8'h00, 0,1,0,1, 8'h07, 0,0));
    vecs.push_back(v("up08", 0,0,8'h00, 0,1,0,1, 8'h08, 0,0));
    vecs.push_back(v("up09", 0,0,8'h00, 0,1,0,1, 8'h09, 0,0));
    vecs.push_back(v("up10", 0,0,8'h00, 0,1,0,1, 8'h10, 0,0));
    vecs.push_back(v("up11", 0,0,8'h00, 0,1,0,1, 8'h11, 0,0));
    vecs.push_back(v("up12", 0,0,8'h00, 0,1,0,1, 8'h12, 0,0));
    // Decimal wrap 98 -> 99 -> 00 with a single wrap pulse.
    vecs.push_back(v("ld98", 0,1,8'h98, 0,1,0,1, 8'h98, 0,0));
    vecs.push_back(v("to99", 0,0,8'h00, 0,1,0,1, 8'h99, 1,0));
    vecs.push_back(v("wrapd", 0,0,8'h00, 0,1,0,1, 8'h00, 0,1));
    vecs.push_back(v("postw", 0,0,8'h00, 0,1,0,1, 8'h01, 0,0));
    // Hex down saturate at 0, then wrap to FF.
    vecs.push_back(v("clr", 1,0,8'h00, 1,0,0,0, 8'h00, 1,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v("sat0", 0,0,8'h00, 1,0,0,0, 8'h00, 1,0));
    vecs.push_back(v("wrapFF", 0,0,8'h00, 1,0,0,1, 8'hFF, 0,1));
    vecs.push_back(v("pauseFF", 0,0,8'h00, 1,0,1,1, 8'hFF, 0,0));
    // Illegal decimal digit recovery.
    vecs.push_back(v("ld3C", 0,1,8'h3C, 0,1,0,1, 8'h3C, 0,0));
    vecs.push_back(v("rec40", 0,0,8'h00, 0,1,0,1, 8'h40, 0,0));
    vecs.push_back(v("ld3Cd", 0,1,8'h3C, 0,0,0,1, 8'h3C, 0,0));
    vecs.push_back(v("rec39", 0,0,8'h00, 0,0,0,1, 8'h39, 0,0));
    // Pause then clear+load+pause: clear wins.
    vecs.push_back(v("ld45", 0,1,8'h45, 0,1,0,1, 8'h45, 0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v("hold45", 0,0,8'h00, 0,1,1,1, 8'h45, 0,0));
    vecs.push_back(v("clrwins", 1,1,8'h77, 0,1,1,1, 8'h00, 0,0));
    // Decimal up saturate at 99.
    vecs.push_back(v("ld99", 0,1,8'h99, 0,1,0,0, 8'h99, 1,0));
    vecs.push_back(v("sat99", 0,0,8'h00, 0,1,0,0, 8'h99, 1,0));
    vecs.push_back(v("hex99", 0,0,8'h00, 1,1,0,0, 8'h9A, 0,0));
    // Illegal top digit overflow: held without wrap, wraps when enabled.
    vecs.push_back(v("ldF9", 0,1,8'hF9, 0,1,0,0, 8'hF9, 0,0));
    vecs.push_back(v("holdF9", 0,0,8'h00, 0,1,0,0, 8'hF9, 0,0));
    vecs.push_back(v("wrapF9", 0,0,8'h00, 0,1,0,1, 8'h00, 0,1));
    // Hex carry/borrow across digits, decimal down wrap.
    vecs.push_back(v("ld2F", 0,1,8'h2F, 1,1,0,1, 8'h2F, 0,0));
    vecs.push_back(v("hx30", 0,0,8'h00, 1,1,0,1, 8'h30, 0,0));
    vecs.push_back(v("hx2F", 0,0,8'h00, 1,0,0,1, 8'h2F, 0,0));
    vecs.push_back(v("clr2", 1,0,8'h00, 0,0,0,1, 8'h00, 1,0));
    vecs.push_back(v("dn99", 0,0,8'h00, 0,0,0,1, 8'h99, 0,1));
    vecs.push_back(v("dn98", 0,0,8'h00, 0,0,0,1, 8'h98, 0,0));
    // Pending wrap pulse dropped by reset.
    vecs.push_back(v("ldFF", 0,1,8'hFF, 1,1,0,1, 8'hFF, 1,0));
    vecs.push_back(v("wrapH", 0,0,8'h00, 1,1,0,1, 8'h00, 0,1));
    run_table();
    mid_reset("rst_wrap");

    // Reset between edges while counting hex, then resume from 0.
    vecs.push_back(v("ld57", 0,1,8'h57, 1,1,0,1, 8'h57, 0,0));
    vecs.push_back(v("hx58", 0,0,8'h00, 1,1,0,1, 8'h58, 0,0));
    run_table();
    mid_reset("rst_mid");
    vecs.push_back(v("resume", 0,0,8'h00, 1,1,0,1, 8'h01, 0,0));
    vecs.push_back(v("resume2", 0,0,8'h00, 1,1,0,1, 8'h02, 0,0));
    run_table();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
